// File: rtl/i2c_config_sequencer.sv
// I2C write-only config sequencer: streams a 16-bit init table (or host words)
// to one slave as {addr,W}, hi, lo with per-word NACK retry.
module i2c_config_sequencer #(
  parameter int          CLK_DIV     = 125,
  parameter int          NUM_ENTRIES = 11,
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int          MAX_RETRY   = 3,
  localparam int         IW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [IW-1:0] tbl_idx,
  input  logic [15:0]   tbl_word,
  input  logic          cmd_valid,
  input  logic [15:0]   cmd_word,
  output logic          cmd_ready,
  output logic          busy,
  output logic          init_done,
  output logic          error,
  output logic [3:0]    retry_cnt,
  output logic          i2c_scl,
  output logic          i2c_sda_oe,
  input  logic          i2c_sda_in
);

  localparam int            DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [15:0]   word_q, word_d;
  logic          host_q, host_d;
  logic          nack_q, nack_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    retry_q, retry_d;
  logic          init_q, init_d;
  logic          err_q, err_d;

  logic       tick, last_ph;
  logic [7:0] cur_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      host_q  <= 1'b0;
      nack_q  <= 1'b0;
      idx_q   <= '0;
      retry_q <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      host_q  <= host_d;
      nack_q  <= nack_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      init_q  <= init_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    host_d  = host_q;
    nack_d  = nack_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    init_d  = init_q;
    err_d   = err_q;
    i2c_scl    = 1'b1;
    i2c_sda_oe = 1'b0;

    busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    cmd_ready = (state_q == S_IDLE) && init_q && !start;
    tick      = busy && (div_q == DIV_LAST);
    last_ph   = tick && (ph_q == 2'd3);

    // Divider and phase free-run while busy and sit at zero otherwise, so every
    // transaction starts on a fresh quarter-bit boundary.
    if (busy) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) ph_d = ph_q + 1'b1;
    end else begin
      div_d = '0;
      ph_d  = '0;
    end

    case (byte_q)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          init_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          host_d  = 1'b0;
          state_d = S_START;
        end else if (cmd_ready && cmd_valid) begin
          word_d  = cmd_word;
          host_d  = 1'b1;
          retry_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        i2c_sda_oe = 1'b1;
        nack_d     = 1'b0;
        // Table words are captured here rather than in IDLE so the holding
        // register always follows the index in effect for this attempt.
        if (!host_q) word_d = tbl_word;
        if (tick && ph_q == 2'd1) begin
          state_d = S_BYTE;
          ph_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_BYTE: begin
        i2c_scl    = ph_q[1];
        i2c_sda_oe = ~cur_byte[3'd7 - bit_q];
        if (last_ph) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        i2c_scl = ph_q[1];
        if (tick && ph_q == 2'd2) nack_d = i2c_sda_in;
        if (last_ph) begin
          if (nack_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_BYTE;
          end
        end
      end
      S_STOP: begin
        i2c_scl    = (ph_q != 2'd0);
        i2c_sda_oe = ~ph_q[1];
        if (last_ph) state_d = S_GAP;
      end
      S_GAP: begin
        if (last_ph) begin
          if (nack_q) begin
            if (retry_q < 4'(MAX_RETRY)) begin
              retry_d = retry_q + 4'd1;
              state_d = S_START;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end else if (host_q) begin
            state_d = S_DONE;
          end else if (idx_q == IDX_LAST) begin
            init_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            retry_d = '0;
            state_d = S_START;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tbl_idx   = idx_q;
  assign init_done = init_q;
  assign error     = err_q;
  assign retry_cnt = retry_q;

endmodule
